// File: rtl/camo_key_pkg.sv
// Shared types and defaults for the c432 select-key loader.
// Lockout support is compiled in with CAMO_KEY_LOCKOUT_EN.
package camo_key_pkg;

    localparam int KEY_W_DEF    = 12;
    localparam int CNT_W_DEF    = 4;
    localparam int FAIL_MAX_DEF = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        PARITY = 3'd2,
        CHECK  = 3'd3,
        LOCKED = 3'd4
    } state_t;

    // Even parity over key plus parity bit: true when total ones count is even.
    function automatic logic parity_even(input logic [KEY_W_DEF-1:0] key, input logic p);
        return ~(^key ^ p);
    endfunction

endpackage

// File: rtl/camo_key_if.sv
// Serial key-delivery bus between the key store and the loader, plus the
// parallel key presented to the camouflaged core.
interface camo_key_if #(
    parameter int KEY_W = 12
);
    // key_sdi is consumed on every cycle key_sdi_vld is high while the loader
    // is shifting; there is no ready, so the source must only pace with vld.
    logic             start;
    logic             key_sdi;
    logic             key_sdi_vld;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             busy;
    logic             err;
    logic             locked;

    modport master (
        output start, key_sdi, key_sdi_vld,
        input  key_out, key_valid, busy, err, locked
    );

    modport slave (
        input  start, key_sdi, key_sdi_vld,
        output key_out, key_valid, busy, err, locked
    );
endinterface

// File: rtl/camo_key_shreg.sv
// Shadow shift register for the select key: LSB-first capture, bit counter
// and a running XOR so parity is ready the moment the parity bit arrives.
module camo_key_shreg #(
    parameter int KEY_W = 12,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift,
    input  logic             sdi,
    output logic [KEY_W-1:0] data,
    output logic             done,
    output logic             xor_acc
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data    <= '0;
            cnt     <= '0;
            xor_acc <= 1'b0;
        end else if (clear) begin
            data    <= '0;
            cnt     <= '0;
            xor_acc <= 1'b0;
        end else if (shift) begin
            // New bits enter at the top so the first bit ends up in s_0.
            data    <= {sdi, data[KEY_W-1:1]};
            cnt     <= cnt + 1'b1;
            xor_acc <= xor_acc ^ sdi;
        end
    end

    // High on the cycle whose shift completes the word.
    assign done = shift && (cnt == CNT_W'(KEY_W - 1));

endmodule

// File: rtl/camo_key_loader.sv
// Serial key loader for the MUX-locked c432 core: shift, parity check, atomic commit.
// Optional lockout after repeated parity failures: define CAMO_KEY_LOCKOUT_EN.
module camo_key_loader
    import camo_key_pkg::*;
#(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
`ifdef CAMO_KEY_LOCKOUT_EN
    ,
    parameter int FAIL_MAX = FAIL_MAX_DEF
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    camo_key_if.slave       bus,
    output state_t          dbg_state
);
    state_t           state;
    logic [KEY_W-1:0] key_out_q;
    logic             key_valid_q;
    logic             busy_q;
    logic             err_q;
    logic             par_ok;

    logic [KEY_W-1:0] shadow;
    logic             sh_clear;
    logic             sh_shift;
    logic             sh_done;
    logic             sh_xor;

    assign sh_clear = (state == IDLE) && bus.start;
    assign sh_shift = (state == SHIFT) && bus.key_sdi_vld;

    camo_key_shreg #(
        .KEY_W (KEY_W),
        .CNT_W (CNT_W)
    ) u_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (sh_clear),
        .shift   (sh_shift),
        .sdi     (bus.key_sdi),
        .data    (shadow),
        .done    (sh_done),
        .xor_acc (sh_xor)
    );

`ifdef CAMO_KEY_LOCKOUT_EN
    localparam int FC_W = $clog2(FAIL_MAX + 1);
    logic [FC_W-1:0] fail_cnt;
    logic            locked_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            key_out_q   <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            par_ok      <= 1'b0;
`ifdef CAMO_KEY_LOCKOUT_EN
            fail_cnt    <= '0;
            locked_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= SHIFT;
                        busy_q      <= 1'b1;
                        err_q       <= 1'b0;
                        key_valid_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (sh_done) begin
                        state <= PARITY;
                    end
                end
                PARITY: begin
                    if (bus.key_sdi_vld) begin
                        par_ok <= (sh_xor == bus.key_sdi);
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                    if (par_ok) begin
                        key_out_q   <= shadow;
                        key_valid_q <= 1'b1;
`ifdef CAMO_KEY_LOCKOUT_EN
                        fail_cnt    <= '0;
`endif
                    end else begin
                        err_q <= 1'b1;
`ifdef CAMO_KEY_LOCKOUT_EN
                        if (fail_cnt == FC_W'(FAIL_MAX - 1)) begin
                            fail_cnt    <= FC_W'(FAIL_MAX);
                            state       <= LOCKED;
                            locked_q    <= 1'b1;
                            key_out_q   <= '0;
                            key_valid_q <= 1'b0;
                        end else begin
                            fail_cnt <= fail_cnt + 1'b1;
                        end
`endif
                    end
                end
`ifdef CAMO_KEY_LOCKOUT_EN
                LOCKED: begin
                    // Only rst_n leaves this state; key stays forced to zero.
                    state       <= LOCKED;
                    key_out_q   <= '0;
                    key_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
`endif
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.key_out   = key_out_q;
    assign bus.key_valid = key_valid_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
`ifdef CAMO_KEY_LOCKOUT_EN
    assign bus.locked    = locked_q;
`else
    assign bus.locked    = 1'b0;
`endif
    assign dbg_state     = state;

endmodule

// File: tb/tb_camo_key_loader.sv
// Directed and randomized bench for camo_key_loader with a transaction-level model.
// Model follows CAMO_KEY_LOCKOUT_EN the same way the design does.
module tb_camo_key_loader;
    import camo_key_pkg::*;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b1;
    state_t dbg_state;

    int checks   = 0;
    int failures = 0;

    camo_key_if #(.KEY_W(12)) bus ();

    camo_key_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Transaction-level model of what the core should see.
    logic [11:0] m_key;
    logic        m_valid;
    logic        m_err;
    logic        m_locked;
    int          m_fails;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_key    = '0;
        m_valid  = 1'b0;
        m_err    = 1'b0;
        m_locked = 1'b0;
        m_fails  = 0;
    endtask

    task automatic model_load(input logic [11:0] k, input logic p);
        if (m_locked) return;
        if (((^k) ^ p) == 1'b0) begin
            m_key   = k;
            m_valid = 1'b1;
            m_err   = 1'b0;
            m_fails = 0;
        end else begin
            m_valid = 1'b0;
            m_err   = 1'b1;
            m_fails++;
`ifdef CAMO_KEY_LOCKOUT_EN
            if (m_fails >= 3) begin
                m_locked = 1'b1;
                m_key    = '0;
            end
`endif
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_key"},    32'(bus.key_out),   32'(m_key));
        chk({tag, "_valid"},  32'(bus.key_valid), 32'(m_valid));
        chk({tag, "_err"},    32'(bus.err),       32'(m_err));
        chk({tag, "_busy"},   32'(bus.busy),      32'(0));
        chk({tag, "_locked"}, 32'(bus.locked),    32'(m_locked));
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.key_sdi     = 1'b0;
        bus.key_sdi_vld = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        model_reset();
    endtask

    // One load: start pulse, 12 key bits LSB first, parity bit, then CHECK.
    task automatic do_load(input string tag, input logic [11:0] k, input logic p, input bit gappy);
        bus.start       = 1'b1;
        bus.key_sdi_vld = gappy ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.key_sdi     = 1'($urandom_range(0, 1));
        tick();
        bus.start       = 1'b0;
        bus.key_sdi_vld = 1'b0;
        if (!m_locked) chk({tag, "_busy_start"}, 32'(bus.busy), 32'(1));
        for (int i = 0; i < 13; i++) begin
            if (gappy) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.key_sdi_vld = 1'b0;
                    bus.key_sdi     = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            bus.key_sdi_vld = 1'b1;
            bus.key_sdi     = (i < 12) ? k[i] : p;
            tick();
        end
        bus.key_sdi_vld = 1'b0;
        if (!m_locked) begin
            chk({tag, "_valid_in_check"}, 32'(bus.key_valid), 32'(0));
            chk({tag, "_key_hold"},       32'(bus.key_out),   32'(m_key));
        end
        tick();
        model_load(k, p);
        check_outputs(tag);
    endtask

    initial begin
        logic [11:0] rk;
        logic        rp;
        bus.start       = 1'b0;
        bus.key_sdi     = 1'b0;
        bus.key_sdi_vld = 1'b0;
        #2;
        do_reset();

        check_outputs("reset");
        chk("reset_state", 32'(dbg_state), 32'(IDLE));

        // Good parity A5C: key committed on the edge after the parity edge.
        do_load("a5c_good", 12'hA5C, 1'b0, 1'b0);

        // Same key, wrong parity: previous key stays, err set.
        do_load("a5c_bad", 12'hA5C, 1'b1, 1'b0);

        // 12'h001 with vld toggling and a stray start mid-load: 27 edges total.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        begin
            logic [11:0] k1;
            k1 = 12'h001;
            for (int i = 0; i < 13; i++) begin
                bus.key_sdi_vld = 1'b1;
                bus.key_sdi     = (i < 12) ? k1[i] : 1'b1;
                tick();
                if (i < 12) begin
                    bus.key_sdi_vld = 1'b0;
                    bus.start       = (i == 5);
                    tick();
                    bus.start = 1'b0;
                end
            end
        end
        bus.key_sdi_vld = 1'b0;
        chk("toggle_busy_26", 32'(bus.busy), 32'(1));
        chk("toggle_valid_26", 32'(bus.key_valid), 32'(0));
        tick();
        model_load(12'h001, 1'b1);
        check_outputs("toggle_27");

        // Reset partway through reloading over FFF.
        do_load("fff_good", 12'hFFF, 1'b0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.key_sdi_vld = 1'b1;
            bus.key_sdi     = 1'($urandom_range(0, 1));
            tick();
        end
        bus.key_sdi_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_key", 32'(bus.key_out), 32'(0));
        chk("midrst_valid", 32'(bus.key_valid), 32'(0));
        chk("midrst_busy", 32'(bus.busy), 32'(0));
        tick();
        rst_n = 1'b1;
        tick();
        model_reset();
        check_outputs("after_midrst");

        // Randomized loads with random gaps and mostly-correct parity.
        for (int n = 0; n < 16; n++) begin
            rk = 12'($urandom_range(0, 4095));
            rp = (^rk) ^ ($urandom_range(0, 3) == 0);
            do_load("rand", rk, rp, 1'b1);
        end

        // Three consecutive bad-parity loads, then a good one.
        do_reset();
        do_load("bad1", 12'hA5C, 1'b1, 1'b0);
        do_load("bad2", 12'hA5C, 1'b1, 1'b0);
        do_load("bad3", 12'hA5C, 1'b1, 1'b0);
        do_load("after_bad", 12'h3C3, 1'b0, 1'b0);
`ifdef CAMO_KEY_LOCKOUT_EN
        chk("lock_flag", 32'(bus.locked), 32'(1));
`else
        chk("lock_flag", 32'(bus.locked), 32'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
